// File: rtl/fp_norm_round_pack_if.sv
// Handshake and data bundle between the FP adder core, the normalize/round/pack
// back end, and the downstream consumer of packed binary32 results.
interface fp_norm_round_pack_if;
    // raw-sum side (adder core -> back end)
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_sum;
    logic [7:0]  in_exp;
    logic        in_sticky;

    // result side (back end -> consumer)
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_ovf;
    logic        out_inexact;

    // Producer of raw sums and consumer of results.
    modport master (
        output in_valid,
        output in_sum,
        output in_exp,
        output in_sticky,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_res,
        input  out_ovf,
        input  out_inexact
    );

    // The normalize/round/pack block itself.
    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_exp,
        input  in_sticky,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_res,
        output out_ovf,
        output out_inexact
    );
endinterface

// File: rtl/fp_norm_round_pack.sv
// Back end of the binary32 adder path: renormalizes the signed, aligned raw sum
// one left shift per cycle, rounds to nearest-even and packs the IEEE-754 word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | in_ready high, waiting for a raw sum
// S_NORM  | one normalization decision per cycle (zero, inf, >>1, <<1)
// S_ROUND | round-to-nearest-even, overflow detect, pack result
// S_DONE  | out_valid high, result held until out_ready
module fp_norm_round_pack #(
    parameter int MAX_LSH = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_norm_round_pack_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(MAX_LSH + 1);

    state_t             r_state;
    logic               r_sign;
    logic [26:0]        r_mag;
    // One spare bit so exp+1 after a carry-out or right shift can reach 256.
    logic [8:0]         r_exp;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_lsh_cnt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_res;
    logic               r_ovf;
    logic               r_inexact;

    // |in_sum| fits in 27 bits because -2^27 is never presented, so negating
    // only the low 27 bits yields the exact magnitude.
    logic [26:0]        w_in_mag;
    logic [8:0]         w_in_exp;

    logic               w_inc;
    logic [24:0]        w_sig_rnd;
    logic [8:0]         w_exp_rnd;
    logic [22:0]        w_frac;
    logic               w_inexact;
    logic               w_ovf;

    assign w_in_mag = bus.in_sum[27] ? (27'd0 - bus.in_sum[26:0]) : bus.in_sum[26:0];
    assign w_in_exp = (bus.in_exp == 8'd0) ? 9'd1 : {1'b0, bus.in_exp};

    // Rounding datapath: lsb=mag[2], guard=mag[1], round=mag[0], sticky below.
    assign w_inc     = r_mag[1] & (r_mag[0] | r_sticky | r_mag[2]);
    assign w_sig_rnd = {1'b0, r_mag[25:2]} + {24'd0, w_inc};
    assign w_inexact = r_mag[1] | r_mag[0] | r_sticky;

    // Exponent field after rounding: carry-out bumps the exponent, and a
    // subnormal (hidden bit clear) only gains exponent field 1 if rounding
    // pushed it up into the hidden-bit position.
    always_comb begin
        w_exp_rnd = r_exp;
        w_frac    = w_sig_rnd[22:0];
        if (w_sig_rnd[24]) begin
            w_exp_rnd = r_exp + 9'd1;
            w_frac    = 23'd0;
        end else if (!r_mag[25]) begin
            w_exp_rnd = {8'd0, w_sig_rnd[23]};
        end
    end

    assign w_ovf = (w_exp_rnd >= 9'd255);

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_mag       <= 27'd0;
            r_exp       <= 9'd0;
            r_sticky    <= 1'b0;
            r_lsh_cnt   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= 32'd0;
            r_ovf       <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.in_sum[27];
                        r_mag      <= w_in_mag;
                        r_exp      <= w_in_exp;
                        r_sticky   <= bus.in_sticky;
                        r_lsh_cnt  <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (r_mag == 27'd0) begin
                        // exact cancellation always gives +0
                        r_res       <= 32'd0;
                        r_ovf       <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_exp == 9'd255) begin
                        // larger operand was already inf: propagate, not an overflow
                        r_res       <= {r_sign, 8'hFF, 23'd0};
                        r_ovf       <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_mag[26]) begin
                        // carry out of the add: one right shift, the lost bit joins sticky
                        r_mag    <= {1'b0, r_mag[26:1]};
                        r_sticky <= r_sticky | r_mag[0];
                        r_exp    <= r_exp + 9'd1;
                        r_state  <= S_ROUND;
                    end else if (r_mag[25]) begin
                        r_state <= S_ROUND;
                    end else if (r_exp == 9'd1) begin
                        // cannot go lower: round as subnormal
                        r_state <= S_ROUND;
                    end else if (r_lsh_cnt == CNT_W'(MAX_LSH)) begin
                        // shift budget exhausted; unreachable for a 27-bit magnitude
                        r_state <= S_ROUND;
                    end else begin
                        r_mag     <= {r_mag[25:0], 1'b0};
                        r_exp     <= r_exp - 9'd1;
                        r_lsh_cnt <= r_lsh_cnt + 1'b1;
                    end
                end

                S_ROUND: begin
                    if (w_ovf) begin
                        r_res     <= {r_sign, 8'hFF, 23'd0};
                        r_ovf     <= 1'b1;
                        r_inexact <= 1'b1;
                    end else begin
                        r_res     <= {r_sign, w_exp_rnd[7:0], w_frac};
                        r_ovf     <= 1'b0;
                        r_inexact <= w_inexact;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_res     = r_res;
    assign bus.out_ovf     = r_ovf;
    assign bus.out_inexact = r_inexact;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Self-checking bench for fp_norm_round_pack: directed cases, backpressure,
// mid-operation reset, then randomized sums checked against an arithmetic
// reference model of round-to-nearest-even binary32 packing.
module tb_fp_norm_round_pack;

    localparam int MAX_LSH = 25;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_norm_round_pack_if bus ();

    fp_norm_round_pack #(.MAX_LSH(MAX_LSH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value = |sum| * 2^(e-152) (+ a sliver if sticky), quantized
    // to the binary32 grid at the result's exponent, ties to even.
    function automatic void ref_model(input logic [27:0] s, input logic [7:0] ein, input logic st,
                                      output logic [31:0] res, output logic ovf, output logic inx,
                                      output int lat);
        logic        sg;
        logic [27:0] a;
        longint      mag, n, rem, half;
        int          e, p, big_e, q, sh, k, field;
        bit          up;
        sg  = s[27];
        a   = sg ? (28'd0 - s) : s;
        mag = a;
        e   = (ein == 8'd0) ? 1 : int'(ein);
        ovf = 1'b0;
        inx = 1'b0;
        if (mag == 0) begin
            res = 32'd0;
            lat = 1;
            return;
        end
        if (e == 255) begin
            res = {sg, 8'hFF, 23'd0};
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 27; i++) if (mag[i]) p = i;
        lat = (p >= 25) ? 2 : 2 + (((25 - p) < (e - 1)) ? (25 - p) : (e - 1));
        big_e = p + e - 152;
        q     = ((big_e < -126) ? -126 : big_e) - 23;
        sh    = e - 152 - q;
        if (sh >= 0) begin
            n   = mag <<< sh;
            up  = 1'b0;
            inx = st;
        end else begin
            k    = -sh;
            n    = mag >>> k;
            rem  = mag & ((longint'(1) <<< k) - 1);
            half = longint'(1) <<< (k - 1);
            up   = (rem > half) || (rem == half && (st || n[0]));
            inx  = (rem != 0) || st;
        end
        n = n + (up ? 1 : 0);
        if (n == (longint'(1) <<< 24)) begin
            n = longint'(1) <<< 23;
            q = q + 1;
        end
        field = (n < (longint'(1) <<< 23)) ? 0 : q + 150;
        if (field >= 255) begin
            res = {sg, 8'hFF, 23'd0};
            ovf = 1'b1;
            inx = 1'b1;
        end else begin
            res = {sg, 8'(field), n[22:0]};
        end
    endfunction

    // Present one sum (entered at a negedge with in_ready high) and wait for
    // out_valid; lat counts rising edges after the accept edge.
    task automatic run_txn(input logic [27:0] s, input logic [7:0] e, input logic st,
                           output logic [31:0] res, output logic ovf, output logic inx,
                           output int lat);
        bus.in_sum    = s;
        bus.in_exp    = e;
        bus.in_sticky = st;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = bus.out_res;
        ovf = bus.out_ovf;
        inx = bus.out_inexact;
    endtask

    task automatic txn_check(input string tag, input logic [27:0] s, input logic [7:0] e,
                             input logic st, input logic [31:0] x_res, input logic x_ovf,
                             input logic x_inx, input int x_lat);
        logic [31:0] res;
        logic        ovf, inx;
        int          lat;
        run_txn(s, e, st, res, ovf, inx, lat);
        check({tag, " res"}, res, x_res);
        check({tag, " ovf"}, 32'(ovf), 32'(x_ovf));
        check({tag, " inexact"}, 32'(inx), 32'(x_inx));
        check({tag, " latency"}, 32'(lat), 32'(x_lat));
        check({tag, " shift limit"}, 32'(lat <= 2 + MAX_LSH), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " in_ready after"}, 32'(bus.in_ready), 32'd1);
        check({tag, " out_valid after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] res, x_res;
        logic        ovf, inx, x_ovf, x_inx;
        int          lat, x_lat;
        logic [26:0] m, mask;
        logic [27:0] s;
        logic [7:0]  e;
        logic        st;
        int          w, sel;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = 28'd0;
        bus.in_exp    = 8'd0;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_res", bus.out_res, 32'd0);
        check("reset flags", {30'd0, bus.out_ovf, bus.out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn_check("one_plus_one", 28'h4000000, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 2);
        txn_check("cancel", 28'h0000004, 8'd127, 1'b0, 32'h34000000, 1'b0, 1'b0, 25);
        txn_check("negative", 28'hE000000, 8'd128, 1'b0, 32'hC0000000, 1'b0, 1'b0, 2);
        txn_check("tie_down", 28'h2000002, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b1, 2);
        txn_check("tie_up", 28'h2000006, 8'd127, 1'b0, 32'h3F800002, 1'b0, 1'b1, 2);
        txn_check("overflow", 28'h7FFFFFF, 8'd254, 1'b0, 32'h7F800000, 1'b1, 1'b1, 2);
        txn_check("zero", 28'h0000000, 8'd127, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
        txn_check("max_shift", 28'h0000001, 8'd127, 1'b0, 32'h33000000, 1'b0, 1'b0, 27);

        // backpressure: result must hold and new requests must be ignored
        bus.out_ready = 1'b0;
        run_txn(28'h4000000, 8'd127, 1'b0, res, ovf, inx, lat);
        check("bp res", res, 32'h40000000);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 28'h0000004;
            @(posedge clk);
            @(negedge clk);
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp out_res", bus.out_res, 32'h40000000);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        repeat (30) @(negedge clk);
        check("bp no queued op", 32'(bus.out_valid), 32'd0);

        // reset in the middle of a long normalization
        bus.in_sum   = 28'h0000004;
        bus.in_exp   = 8'd127;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midreset discarded", 32'(bus.out_valid), 32'd0);
        txn_check("after_reset", 28'h4000000, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 2);

        // randomized sums against the reference model
        for (int t = 0; t < 300; t++) begin
            w    = $urandom_range(0, 27);
            mask = (27'd1 << w) - 27'd1;
            if (w == 27) mask = '1;
            m    = 27'($urandom) & mask;
            s    = $urandom_range(0, 1) ? (28'd0 - {1'b0, m}) : {1'b0, m};
            sel  = $urandom_range(0, 9);
            case (sel)
                0:       e = 8'd0;
                1:       e = 8'd1;
                2:       e = 8'd255;
                3:       e = 8'd254;
                4:       e = 8'($urandom_range(2, 24));
                default: e = 8'($urandom_range(1, 254));
            endcase
            st = 1'($urandom_range(0, 1));
            ref_model(s, e, st, x_res, x_ovf, x_inx, x_lat);
            txn_check("random", s, e, st, x_res, x_ovf, x_inx, x_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_norm_round_pack.md
Name: fp_norm_round_pack

Overview:
- Back end of the single-precision FP adder path: takes the signed, exponent-aligned raw sum from the adder core and produces a normalized, rounded IEEE-754 binary32 word.
- Front end denormalizes (aligns); this block renormalizes and packs.
- Iterative: one left-shift per cycle, valid/ready handshake on both sides, one result in flight.

Parameters:
- MAX_LSH, 25, maximum left-normalization shifts; the bench checks that the limit is never exceeded.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  raw sum valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_sum  in  28  two's-complement raw sum. Magnitude layout: bit26 carry, bit25 hidden, bits24:2 fraction, bit1 guard, bit0 round.
- in_exp  in  8  biased exponent of larger operand. 0 is treated as 1.
- in_sticky  in  1  OR of bits shifted out during alignment
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  32  IEEE-754 binary32 result
- out_ovf  out  1  result overflowed to infinity
- out_inexact  out  1  guard, round or sticky was nonzero at rounding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_res=0; out_ovf=0; out_inexact=0.
  - Internal regs cleared. Reset mid-operation discards the operation.
- Value represented: mag * 2^(exp-127-25), where mag=|in_sum| (27 bits; -2^27 never presented).
- IDLE:
  - in_ready=1.
  - On in_valid: latch sign=in_sum[27], mag, exp (0 becomes 1), sticky; shift counter=0; go to NORM.
- NORM, one decision per cycle, first matching rule wins:
  - mag==0: result +0 (sign forced 0), flags 0; go to DONE.
  - exp==255: result = sign, 0xFF, fraction 0 (infinity); ovf=0; go to DONE.
  - mag[26]=1: shift right 1; sticky |= mag[0]; exp+1; go to ROUND.
  - mag[25]=1: go to ROUND.
  - exp==1: go to ROUND as subnormal (exponent field 0).
  - Otherwise: shift left 1, zero fill; exp-1; counter+1; stay in NORM.
- ROUND (round-to-nearest-even):
  - Fields: lsb=mag[2], g=mag[1], r=mag[0], s=sticky.
  - Increment when g & (r|s|lsb).
  - inexact = g|r|s.
  - Increment carries out of 24-bit significand: significand becomes 1.0, exp+1.
  - Subnormal that rounds to mag[25]=1: exponent field becomes 1.
  - exp>=255 after rounding: infinity, ovf=1, inexact=1.
  - Pack {sign, exp field, mag[24:2]}; go to DONE.
- DONE:
  - out_valid=1; out_res and flags stable.
  - out_ready=1: go to IDLE. out_valid drops and in_ready rises on the next cycle.
  - out_ready=0: hold indefinitely.
- No input accepted outside IDLE. in_valid in other states is ignored (no queuing).
- Latency: accept edge E, then out_valid high after edge E+2+k, where k is the number of left shifts (0..MAX_LSH).
- Outputs are registered. No combinational in→out path.

Test Plan:
- 1.0+1.0: in_sum=28'h4000000, in_exp=127, sticky=0 -> out_res=32'h40000000, ovf=0, inexact=0, out_valid 2 cycles after accept.
- Cancellation: in_sum=28'h0000004, in_exp=127 -> 23 left shifts; out_res=32'h34000000 (2^-23); out_valid at E+25.
- Negative: in_sum=28'hE000000 (-2^25), in_exp=128 -> out_res=32'hC0000000.
- Ties:
  - in_sum=28'h2000002, exp 127, sticky 0 -> 32'h3F800000, inexact=1 (round down to even).
  - in_sum=28'h2000006 -> 32'h3F800002, inexact=1 (round up).
- Overflow: in_sum=28'h7FFFFFF, in_exp=254 -> out_res=32'h7F800000, out_ovf=1, out_inexact=1.
- Zero, backpressure, reset:
  - in_sum=0 -> out_res=32'h00000000.
  - Hold out_ready=0 for 5 cycles -> out_valid and out_res stable, in_ready=0, extra in_valid ignored.
  - Then rst_n low mid-NORM on a cancellation case -> out_valid=0 and in_ready=1 immediately.
